// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit:
// operation encoding, flag bit positions and lookahead group width.
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  // Positions inside the {N, Z, C, V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int GROUP_W = 4;

endpackage

// File: rtl/cla_slice.sv
// Combinational N-bit adder built from 4-bit carry-lookahead groups;
// group carries ripple from one group to the next.
module cla_slice
  import cla_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry inside a group is expanded from that group's carry-in,
  // so the group's internal carries do not ripple.
  always_comb begin
    // NOTE: assign the whole vector first so no bit is left holding its old value (latch).
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < N / GROUP_W; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract: each stage adds one WIDTH/STAGES slice, LSB first,
// carrying the unprocessed operand bits and the finished sum bits alongside.
module pipe_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic [3:0]       o_flags
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % 4 != 0) || (WIDTH < 8) || (STAGES < 1) || (STAGES > 8) ||
      ((WIDTH / 4) % STAGES != 0)) begin : g_bad_param
    $error("pipe_cla_addsub: unsupported WIDTH/STAGES combination");
  end

  // The whole pipeline moves as one: any stall at the output freezes every stage.
  logic adv;
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  always_comb begin
    b_eff   = i_b;
    cin_eff = 1'b0;
    unique case (op_e'(i_op))
      OP_ADD: ;
      OP_SUB: begin
        b_eff   = ~i_b;
        cin_eff = 1'b1;
      end
      OP_ADC: cin_eff = i_cin;
      OP_SBC: begin
        b_eff   = ~i_b;
        cin_eff = i_cin;
      end
    endcase
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * SW;
    localparam int HI = LO + SW;

    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic              c_in;
    logic              v_in;
    logic [SW-1:0]     sl_sum;
    logic              sl_c;
    logic [HI-1:0]     s_nxt;

    if (s == 0) begin : g_head
      assign a_in  = i_a;
      assign b_in  = b_eff;
      assign c_in  = cin_eff;
      assign v_in  = i_valid;
      assign s_nxt = sl_sum;
    end else begin : g_body
      assign a_in  = g_stage[s-1].g_reg.a_q;
      assign b_in  = g_stage[s-1].g_reg.b_q;
      assign c_in  = g_stage[s-1].g_reg.c_q;
      assign v_in  = g_stage[s-1].g_reg.v_q;
      assign s_nxt = {sl_sum, g_stage[s-1].g_reg.s_q};
    end

    cla_slice #(.N(SW)) u_slice (
      .a    (a_in[HI-1:LO]),
      .b    (b_in[HI-1:LO]),
      .cin  (c_in),
      .sum  (sl_sum),
      .cout (sl_c)
    );

    if (s == LAST) begin : g_out
      logic [3:0] flags_nxt;

      // The MSB slice is processed here, so its operand bits are still at hand for V.
      always_comb begin
        flags_nxt         = '0;
        flags_nxt[FLAG_N] = s_nxt[WIDTH-1];
        flags_nxt[FLAG_Z] = (s_nxt == '0);
        flags_nxt[FLAG_C] = sl_c;
        flags_nxt[FLAG_V] = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                            (s_nxt[WIDTH-1] != a_in[WIDTH-1]);
      end

      always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (i_rst) begin
          o_valid <= 1'b0;
          o_sum   <= '0;
          o_flags <= '0;
        end else if (adv) begin
          o_valid <= v_in;
          o_sum   <= s_nxt;
          o_flags <= flags_nxt;
        end
      end
    end else begin : g_reg
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
      logic [HI-1:0]     s_q;
      logic              c_q;
      logic              v_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) v_q <= 1'b0;
        else if (adv) v_q <= v_in;
      end

      // NOTE: payload registers are left unreset; the stage valid bit qualifies them.
      always_ff @(posedge i_clk) begin
        if (adv) begin
          a_q <= a_in[WIDTH-1:HI];
          b_q <= b_in[WIDTH-1:HI];
          s_q <= s_nxt;
          c_q <= sl_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Bench for pipe_cla_addsub (WIDTH=32, STAGES=4): directed vector table,
// stall/reset sequences and a random handshake soak against a scoreboard.
module tb_pipe_cla_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [1:0]       i_op;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic [3:0]       o_flags;

  always #5 i_clk = ~i_clk;

  pipe_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_op    (i_op),
    .i_cin   (i_cin),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_flags (o_flags)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;
  } res_t;

  typedef struct {
    string            name;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  res_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: plain wide addition, flags from their definitions.
  function automatic res_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH-1:0] be;
    logic             ce;
    logic [WIDTH:0]   full;
    res_t             r;
    be = (op == 2'b01 || op == 2'b11) ? ~b : b;
    case (op)
      2'b00:   ce = 1'b0;
      2'b01:   ce = 1'b1;
      default: ce = cin;
    endcase
    full     = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
    r.sum    = full[WIDTH-1:0];
    r.flags  = {r.sum[WIDTH-1], (r.sum == '0), full[WIDTH],
                (a[WIDTH-1] == be[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1])};
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge i_clk) begin
    res_t want;
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: result %h with no transaction outstanding (t=%0t)", o_sum, $time);
      end else begin
        want = sb_q.pop_front();
        check("sb_sum", o_sum, want.sum);
        check("sb_flags", o_flags, want.flags);
        n_out++;
      end
    end
    if (i_rst === 1'b1) sb_q.delete();
    else if (i_valid === 1'b1 && o_ready === 1'b1) sb_q.push_back(model(i_op, i_a, i_b, i_cin));
  end

  task automatic drain();
    int k = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (sb_q.size() != 0 && k < 32) begin
      @(posedge i_clk); #1;
      k++;
    end
    @(posedge i_clk); #1;
    check("drain_empty", sb_q.size(), 0);
  endtask

  task automatic run_vectors();
    int lat;
    for (int i = 0; i < NV; i++) begin
      i_valid = 1'b1;
      i_ready = 1'b1;
      i_op    = vecs[i].op;
      i_a     = vecs[i].a;
      i_b     = vecs[i].b;
      i_cin   = vecs[i].cin;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_a     = $urandom();
      i_b     = $urandom();
      lat     = 1;
      while (!o_valid && lat < 16) begin
        @(posedge i_clk); #1;
        lat++;
      end
      check({vecs[i].name, "_latency"}, lat, STAGES);
      check({vecs[i].name, "_sum"}, o_sum, vecs[i].sum);
      check({vecs[i].name, "_flags"}, o_flags, vecs[i].flags);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic run_stream();
    int               idx = 0;
    int               cyc = 0;
    int               out0;
    bit               acc;
    logic [WIDTH-1:0] snap_sum;
    logic [3:0]       snap_flags;
    out0 = n_out;
    while (idx < 8 && cyc < 64) begin
      i_valid = 1'b1;
      i_op    = idx[1:0];
      i_a     = 32'h1357_9BDF * (idx + 1);
      i_b     = 32'h0F0F_1234 ^ (idx << 20);
      i_cin   = idx[0];
      i_ready = !(cyc >= 5 && cyc <= 7);
      @(negedge i_clk);
      if (cyc == 5) begin
        check("stall_o_ready", o_ready, 0);
        check("stall_o_valid", o_valid, 1);
        snap_sum   = o_sum;
        snap_flags = o_flags;
      end else if (cyc == 6 || cyc == 7) begin
        check("stall_o_ready_hold", o_ready, 0);
        check("stall_o_valid_hold", o_valid, 1);
        check("stall_sum_frozen", o_sum, snap_sum);
        check("stall_flags_frozen", o_flags, snap_flags);
      end
      acc = i_valid && o_ready;
      @(posedge i_clk); #1;
      if (acc) idx++;
      cyc++;
    end
    check("stream_accepted", idx, 8);
    drain();
    check("stream_results", n_out - out0, 8);
  endtask

  task automatic run_reset_in_flight();
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_op    = 2'b00;
      i_a     = 32'h0000_0100 + k;
      i_b     = 32'h0000_0001;
      i_cin   = 1'b0;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_rst   = 1'b1;
    @(posedge i_clk); #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_sum", o_sum, 0);
    check("rst_o_flags", o_flags, 0);
    i_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge i_clk); #1;
      check("post_rst_no_valid", o_valid, 0);
    end
  endtask

  task automatic run_soak();
    int acc_n = 0;
    int cyc   = 0;
    while (acc_n < 10000 && cyc < 80000) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0);
      i_op    = 2'($urandom_range(0, 3));
      i_a     = pick();
      i_b     = pick();
      i_cin   = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      if (i_valid && o_ready) acc_n++;
      @(posedge i_clk); #1;
      cyc++;
    end
    check("soak_accepted", acc_n, 10000);
    drain();
  endtask

  initial begin
    vecs[0]  = '{"add_wrap",     2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110};
    vecs[1]  = '{"sub_ovf",      2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011};
    vecs[2]  = '{"adc_cin",      2'b10, 32'h0000_000F, 32'h0000_0000, 1'b1, 32'h0000_0010, 4'b0000};
    vecs[3]  = '{"sbc_borrow",   2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 4'b0010};
    vecs[4]  = '{"add_ovf",      2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001};
    vecs[5]  = '{"sub_neg",      2'b01, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 4'b1000};
    vecs[6]  = '{"sub_zero",     2'b01, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0110};
    vecs[7]  = '{"add_plain",    2'b00, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 4'b0000};
    vecs[8]  = '{"add_slice_cy", 2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000};
    vecs[9]  = '{"add_no_cin",   2'b00, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0002, 4'b0000};
    vecs[10] = '{"sub_no_cin",   2'b01, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110};
    vecs[11] = '{"sbc_zero",     2'b11, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110};
    vecs[12] = '{"adc_full",     2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 4'b1010};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_op    = 2'b00;
    i_a     = '0;
    i_b     = '0;
    i_cin   = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_o_valid", o_valid, 0);
    check("reset_o_sum", o_sum, 0);
    check("reset_o_flags", o_flags, 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("reset_o_ready", o_ready, 1);

    run_vectors();
    drain();
    run_stream();
    run_reset_in_flight();
    run_soak();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
